// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit detection, mid-bit sampling, stop-bit check and a
// one-entry holding register with a valid/ready handshake. All decisions are gated by
// the oversampling baud tick; data is shifted in LSB first.
module uart_rx_ctrl #(
  parameter int unsigned OVS       = 16,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       baud_tick_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned TcntW = $clog2(OVS);
  localparam logic [TcntW-1:0] TcntMid  = TcntW'(OVS / 2 - 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(OVS - 1);
  localparam logic [2:0]       BitLast  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e                 state_q, state_d;
  logic [TcntW-1:0]       tcnt_q, tcnt_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   rx_meta_q, rxs_q;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;
  logic                   frame_done;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
    end
  end

  // Frame sequencing: counters only move on baud ticks.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    frame_done  = 1'b0;
    frame_err_d = 1'b0;
    if (baud_tick_i) begin
      unique case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            state_d = StStart;
            tcnt_d  = '0;
          end
        end
        StStart: begin
          if (tcnt_q == TcntMid) begin
            tcnt_d = '0;
            if (rxs_q) begin
              state_d = StIdle;  // glitch, not a real start bit
            end else begin
              state_d  = StData;
              bitcnt_d = '0;
            end
          end else begin
            tcnt_d = tcnt_q + TcntW'(1);
          end
        end
        StData: begin
          if (tcnt_q == TcntLast) begin
            tcnt_d   = '0;
            shift_d  = {rxs_q, shift_q[DATA_BITS-1:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == BitLast) state_d = StStop;
          end else begin
            tcnt_d = tcnt_q + TcntW'(1);
          end
        end
        StStop: begin
          if (tcnt_q == TcntLast) begin
            tcnt_d = '0;
            if (rxs_q) begin
              frame_done = 1'b1;
              state_d    = StIdle;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StWaitHigh;
            end
          end else begin
            tcnt_d = tcnt_q + TcntW'(1);
          end
        end
        StWaitHigh: begin
          // A held-low line (break) parks here until it returns high.
          if (rxs_q) begin
            state_d = StIdle;
            tcnt_d  = '0;
          end
        end
        default: begin
          state_d = StIdle;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  // Holding register: load on completion if empty or being drained, else flag overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    busy_d    = (state_d != StIdle);
    if (frame_done) begin
      if (!valid_q || ready_i) begin
        data_d  = 8'(shift_q);
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      tcnt_q      <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: OVS=16, baud tick every cycle, 16 clocks per bit.
// Inputs change 2ns after a rising edge; outputs and monitor counters are read after
// the falling edge.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       baud_tick;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Monitor state
  logic        mon_clr;
  int unsigned cyc = 0;
  int unsigned fe_hi, ov_hi, valid_hi, busy_hi, acc_cnt, valid_rise_cyc;
  logic [7:0]  acc_data;
  logic        valid_prev = 1'b0;
  int unsigned start_cyc = 0;

  uart_rx_ctrl #(
    .OVS      (16),
    .DATA_BITS(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .rx_i       (rx),
    .baud_tick_i(baud_tick),
    .ready_i    (ready),
    .data_o     (data),
    .valid_o    (valid),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts high cycles of each output and records handshakes (valid & ready before an edge).
  always @(negedge clk) begin
    if (mon_clr) begin
      fe_hi          <= 0;
      ov_hi          <= 0;
      valid_hi       <= 0;
      busy_hi        <= 0;
      acc_cnt        <= 0;
      acc_data       <= 8'h00;
      valid_rise_cyc <= 0;
    end else begin
      if (frame_err) fe_hi <= fe_hi + 1;
      if (overrun) ov_hi <= ov_hi + 1;
      if (valid) valid_hi <= valid_hi + 1;
      if (busy) busy_hi <= busy_hi + 1;
      if (valid && ready) begin
        acc_cnt  <= acc_cnt + 1;
        acc_data <= data;
      end
      if (valid && !valid_prev) valid_rise_cyc <= cyc;
    end
    valid_prev <= valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic sample_point();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  // One-cycle ready pulse aligned so the monitor sees the handshake.
  task automatic accept();
    @(posedge clk);
    #2;
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  // Start bit, 8 data bits LSB first, then stop level for stop_len cycles.
  // rdy_at >= 0 raises ready for exactly that one cycle of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len,
                            input int rdy_at);
    @(posedge clk);
    #2;
    for (int c = 0; c < 144 + stop_len; c++) begin
      if (c == 0) start_cyc = cyc;
      if (c < 16) rx = 1'b0;
      else if (c < 144) rx = b[(c - 16) / 16];
      else rx = stop_val;
      if (c == rdy_at) ready = 1'b1;
      else if (rdy_at >= 0 && c == rdy_at + 1) ready = 1'b0;
      step(1);
    end
    rx = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rx        = 1'b1;
    baud_tick = 1'b1;
    ready     = 1'b0;
    mon_clr   = 1'b1;
    step(3);
    check_eq("rst_data", 32'(data), 32'h00);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step(3);

    // 0xA5 with ready held high
    clear_mon();
    ready = 1'b1;
    send_frame(8'hA5, 1'b1, 16, -1);
    step(20);
    sample_point();
    check_eq("a5_accepts", acc_cnt, 1);
    check_eq("a5_data", 32'(acc_data), 32'hA5);
    check_eq("a5_valid_cycles", valid_hi, 1);
    check_eq("a5_valid_now", 32'(valid), 32'h0);
    check_eq("a5_frame_err", fe_hi, 0);
    check_eq("a5_overrun", ov_hi, 0);
    check_eq("a5_busy", 32'(busy), 32'h0);
    // 2 sync edges + 152 ticks to stop sample + 1 register edge
    check_eq("a5_latency", valid_rise_cyc - start_cyc, 155);

    // 4-cycle glitch while idle
    clear_mon();
    @(posedge clk);
    #2;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(30);
    sample_point();
    check_eq("glitch_busy_cycles", busy_hi, 8);
    check_eq("glitch_valid", valid_hi, 0);
    check_eq("glitch_frame_err", fe_hi, 0);
    check_eq("glitch_overrun", ov_hi, 0);
    check_eq("glitch_busy", 32'(busy), 32'h0);

    // 0x3C with stop held low for 3 bit times, then 0x55
    clear_mon();
    send_frame(8'h3C, 1'b0, 48, -1);
    sample_point();
    check_eq("ferr_busy_held", 32'(busy), 32'h1);
    check_eq("ferr_pulse_cycles", fe_hi, 1);
    check_eq("ferr_valid", valid_hi, 0);
    check_eq("ferr_overrun", ov_hi, 0);
    step(6);
    sample_point();
    check_eq("ferr_busy_released", 32'(busy), 32'h0);
    clear_mon();
    send_frame(8'h55, 1'b1, 16, -1);
    step(10);
    sample_point();
    check_eq("post_ferr_accepts", acc_cnt, 1);
    check_eq("post_ferr_data", 32'(acc_data), 32'h55);
    check_eq("post_ferr_frame_err", fe_hi, 0);

    // Overrun: ready low, 0x11 then 0x22
    clear_mon();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 16, -1);
    step(4);
    send_frame(8'h22, 1'b1, 16, -1);
    step(4);
    sample_point();
    check_eq("ovr_valid", 32'(valid), 32'h1);
    check_eq("ovr_data", 32'(data), 32'h11);
    check_eq("ovr_pulse_cycles", ov_hi, 1);
    check_eq("ovr_no_accept", acc_cnt, 0);
    accept();
    sample_point();
    check_eq("ovr_drain_valid", 32'(valid), 32'h0);
    check_eq("ovr_drain_accepts", acc_cnt, 1);
    check_eq("ovr_drain_data", 32'(acc_data), 32'h11);

    // Ready in exactly the completion cycle of 0x22
    clear_mon();
    send_frame(8'h11, 1'b1, 16, -1);
    step(4);
    send_frame(8'h22, 1'b1, 16, 154);
    step(4);
    sample_point();
    check_eq("same_cyc_valid", 32'(valid), 32'h1);
    check_eq("same_cyc_data", 32'(data), 32'h22);
    check_eq("same_cyc_overrun", ov_hi, 0);
    check_eq("same_cyc_accepts", acc_cnt, 1);
    check_eq("same_cyc_first", 32'(acc_data), 32'h11);
    accept();
    sample_point();
    check_eq("same_cyc_drain_valid", 32'(valid), 32'h0);
    check_eq("same_cyc_drain_data", 32'(acc_data), 32'h22);

    // Reset during bit 4 with a byte pending, then 0xF0
    clear_mon();
    send_frame(8'h5A, 1'b1, 16, -1);
    step(4);
    rx = 1'b0;
    step(16);
    rx = 1'b1;
    step(64);
    rx = 1'b0;
    step(8);
    check_eq("pre_rst_valid", 32'(valid), 32'h1);
    check_eq("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_data", 32'(data), 32'h00);
    check_eq("mid_rst_valid", 32'(valid), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("mid_rst_overrun", 32'(overrun), 32'h0);
    step(2);
    rx    = 1'b1;
    rst_n = 1'b1;
    step(20);
    sample_point();
    check_eq("rst_no_ferr", fe_hi, 0);
    check_eq("rst_no_ovr", ov_hi, 0);
    ready = 1'b1;
    send_frame(8'hF0, 1'b1, 16, -1);
    step(10);
    sample_point();
    check_eq("post_rst_accepts", acc_cnt, 1);
    check_eq("post_rst_data", 32'(acc_data), 32'hF0);
    check_eq("post_rst_valid", 32'(valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller that sequences the RX datapath from a free-running 16x oversampling baud tick. It detects the start bit, samples each data bit at mid-bit and checks the stop bit. Each good byte is delivered through a one-entry holding register with a valid/ready handshake to the downstream consumer. It also flags framing errors and overruns, and sits between the RX pin and the UART RX FIFO/CPU interface.

Parameters:
OVS, 16, oversampling ticks per bit; even, at least 4
DATA_BITS, 8, data bits per frame; range 5..8, LSB first; data_o[7:DATA_BITS] driven 0

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-low
rx_i  input  1  asynchronous serial line, idle high
baud_tick_i  input  1  one-clk_i-cycle enable pulse at OVS x baud rate
ready_i  input  1  consumer accepts data_o when high with valid_o
data_o  output  8  received byte, stable while valid_o=1
valid_o  output  1  holding register holds an unread byte
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: good byte dropped because holding register was full
busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_i=0, asynchronous) values:
  - rx synchronizer flops = 1; state = IDLE; tick counter, bit counter, shift register = 0.
  - data_o = 0, valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
  - Reset mid-frame aborts the frame; no pulse is generated and valid_o is cleared.
- rx_i passes through a 2-flop synchronizer (rxs). All decisions use rxs and are taken only in cycles with baud_tick_i=1; counters freeze otherwise.
- Tick counter tcnt: width clog2(OVS), cleared on each state entry.
- State machine:
  - IDLE: on a tick with rxs=0 -> START, tcnt=0.
  - START: on each tick tcnt++. At the tick where tcnt reaches OVS/2-1, sample rxs:
    - rxs=1 -> false start, back to IDLE (no flag).
    - rxs=0 -> DATA, tcnt=0, bit counter=0.
  - DATA: on each tick tcnt++. At tcnt=OVS-1, sample rxs into shift register MSB side (right-shift; first bit ends in bit 0), tcnt=0, bitcnt++. After the DATA_BITS-th sample -> STOP.
  - STOP: at tcnt=OVS-1, sample rxs:
    - rxs=1 -> complete frame, -> IDLE.
    - rxs=0 -> frame_err_o pulses the next cycle, byte discarded, -> WAIT_HIGH.
  - WAIT_HIGH: on a tick with rxs=1 -> IDLE. A break condition holds the block here.
- Holding register:
  - On frame completion with valid_o=0: data_o <= shift register, valid_o <= 1 on the next clk_i edge.
  - On valid_o & ready_i: valid_o <= 0, unless a completion occurs in the same cycle. In that case data_o is loaded with the new byte and valid_o stays 1, with no overrun.
  - On completion while valid_o=1 & ready_i=0: new byte dropped, data_o unchanged, overrun_o pulses one cycle.
  - data_o never changes while valid_o=1 without a handshake.
- Latency: valid_o rises 1 clk_i cycle after the stop-bit sampling tick. The stop-bit sample falls on tick (OVS/2) + (DATA_BITS+1)*OVS after the start edge is seen.
- frame_err_o and overrun_o are registered pulses, exactly 1 clk_i cycle each. They cannot both fire for the same frame.
- busy_o = (state != IDLE), registered with the state.

Test Plan:
- OVS=16, baud_tick_i every cycle; send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with ready_i=1 -> valid_o high 1 cycle, data_o=0xA5, no flags; busy_o low after the stop sample.
- 4-tick low glitch on rx_i while IDLE -> back to IDLE after the mid-start sample; valid_o, frame_err_o, overrun_o stay 0.
- Frame 0x3C with the stop bit held 0 for 3 bit times -> frame_err_o exactly one 1-cycle pulse, valid_o stays 0, busy_o high until rx_i returns high, then the next frame 0x55 is received correctly.
- ready_i=0; send 0x11 then 0x22 -> data_o=0x11, valid_o=1, overrun_o pulses once at the second stop; raising ready_i yields 0x11 and valid_o falls.
- ready_i asserted in exactly the cycle the second byte (0x22) completes -> data_o becomes 0x22, valid_o stays 1, overrun_o=0.
- rst_i pulsed low during bit 4 of a frame -> all outputs 0 immediately; a following clean frame 0xF0 is received as 0xF0.
